// File: rtl/alu_scheduler_pkg.sv
// Shared control types: ALU operation codes and the scheduler FSM states.
package pck_control;

  localparam int ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    alu_nop = 5'd0,
    alu_add = 5'd1,
    alu_sub = 5'd2,
    alu_and = 5'd3,
    alu_or  = 5'd4,
    alu_xor = 5'd5,
    alu_sll = 5'd6,
    alu_srl = 5'd7
  } sel_alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

endpackage

// File: rtl/alu_sched_arbiter.sv
// Combinational requester arbiter: one-hot grant plus encoded index.
// ALU_SCHED_RR_EN selects round-robin from ptr; otherwise lowest index wins.
module alu_sched_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
`ifdef ALU_SCHED_RR_EN
  input  logic [ID_W-1:0]  ptr,
`endif
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  logic            found;
  logic [ID_W-1:0] cand;
`ifdef ALU_SCHED_RR_EN
  logic [ID_W:0]   sum;
`endif

  // Walk candidates in priority order; the first requesting one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
`ifdef ALU_SCHED_RR_EN
    sum   = '0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
`ifdef ALU_SCHED_RR_EN
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      cand = sum[ID_W-1:0];
`else
      cand = ID_W'(i);
`endif
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU among N_REQ requesters: arbitrate, issue, wait fixed latency, respond.
// Optional ALU_SCHED_RR_EN enables round-robin arbitration (default: fixed priority).
module alu_scheduler
  import pck_control::*;
#(
  parameter int BITS    = 8,
  parameter int N_REQ   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ*ALU_OP_W-1:0] i_req_op,
  input  logic [N_REQ*BITS-1:0]     i_req_a,
  input  logic [N_REQ*BITS-1:0]     i_req_b,
  output logic [ALU_OP_W-1:0]       o_alu_sel_op,
  output logic [BITS-1:0]           o_alu_op_a,
  output logic [BITS-1:0]           o_alu_op_b,
  input  logic [BITS-1:0]           i_alu_res,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [$clog2(N_REQ)-1:0]  o_rsp_id,
  output logic [BITS-1:0]           o_rsp_data
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  sched_state_e        state, state_nx;
  logic [ALU_OP_W-1:0] hold_op, sel_op;
  logic [BITS-1:0]     hold_a, hold_b, sel_a, sel_b;
  logic [ID_W-1:0]     hold_id, grant_idx;
  logic [CNT_W-1:0]    cnt;
  logic [BITS-1:0]     rsp_data;
  logic [N_REQ-1:0]    grant;
  logic                accept;
`ifdef ALU_SCHED_RR_EN
  logic [ID_W-1:0]     ptr;
`endif

  alu_sched_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arbiter (
    .req   (i_req_valid),
`ifdef ALU_SCHED_RR_EN
    .ptr   (ptr),
`endif
    .grant (grant),
    .idx   (grant_idx)
  );

  // Grant is only offered in IDLE and is forced low while reset is asserted.
  assign accept      = (state == IDLE) && (|grant);
  assign o_req_ready = (i_rst_n && state == IDLE) ? grant : '0;

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_op = i_req_op[k*ALU_OP_W +: ALU_OP_W];
        sel_a  = i_req_a[k*BITS +: BITS];
        sel_b  = i_req_b[k*BITS +: BITS];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    if (i_rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      hold_op  <= alu_nop;
      hold_a   <= '0;
      hold_b   <= '0;
      hold_id  <= '0;
      cnt      <= '0;
      rsp_data <= '0;
`ifdef ALU_SCHED_RR_EN
      ptr      <= '0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            hold_op <= sel_op;
            hold_a  <= sel_a;
            hold_b  <= sel_b;
            hold_id <= grant_idx;
`ifdef ALU_SCHED_RR_EN
            ptr     <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
`endif
          end
        end
        ISSUE: cnt <= CNT_W'(ALU_LAT-1);
        WAIT: begin
          if (cnt == '0) begin
            rsp_data <= i_alu_res;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ALU pins carry the held operation only while it is in flight.
  always_comb begin
    o_alu_sel_op = alu_nop;
    o_alu_op_a   = '0;
    o_alu_op_b   = '0;
    if (state == ISSUE || state == WAIT) begin
      o_alu_sel_op = hold_op;
      o_alu_op_a   = hold_a;
      o_alu_op_b   = hold_b;
    end
  end

  assign o_rsp_valid = (state == RESP);
  assign o_rsp_id    = hold_id;
  assign o_rsp_data  = rsp_data;

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Shares one `alu_top` instance among `N_REQ` requesters. Each requester presents an operation and operands over a valid/ready handshake. The scheduler arbitrates, issues one operation at a time to the ALU, waits the ALU's fixed latency, and returns the result tagged with the requester index over a valid/ready response channel. It sits between the requesters and the ALU's `i_sel_op`/`i_op_a`/`i_op_b`/`o_res` pins.

## Interface
- `BITS`, 8, operand/result width; must match the ALU.
- `N_REQ`, 4, number of requesters; range 2..16.
- `ALU_LAT`, 2, cycles from ALU inputs driven to `i_alu_res` valid; must be ≥1 (the `alu_top` input register counts).
- `i_clk` in 1: single clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_req_valid` in `N_REQ`: request valid, one bit per requester.
- `o_req_ready` in/out: out `N_REQ`; one-hot grant/accept.
- `i_req_op` in `N_REQ*5`: packed `sel_alu_op_e` codes; requester k at bits [5k+4:5k].
- `i_req_a`, `i_req_b` in `N_REQ*BITS`: packed operands, same indexing.
- `o_alu_sel_op` out 5: operation to the ALU.
- `o_alu_op_a`, `o_alu_op_b` out `BITS`: operands to the ALU.
- `i_alu_res` in `BITS`: ALU result.
- `o_rsp_valid` out 1: response valid.
- `i_rsp_ready` in 1: response consumer ready.
- `o_rsp_id` out `$clog2(N_REQ)`: index of the requester that owns the response.
- `o_rsp_data` out `BITS`: result.

## Operation
- FSM states, in `sched_state_e`: `IDLE`, `ISSUE`, `WAIT`, `RESP`.
- `IDLE`:
  - The arbiter picks one requester among `i_req_valid`.
  - `o_req_ready` is the one-hot grant, driven combinationally, only in `IDLE`.
  - On handshake, capture op, A, B and id into holding registers, then go to `ISSUE`.
  - No valid request: stay in `IDLE`.
- `ISSUE` (one cycle):
  - `o_alu_*` driven from the holding registers.
  - Load the latency counter with `ALU_LAT-1`, then go to `WAIT`.
- `WAIT`:
  - `o_alu_*` is held stable.
  - The counter decrements; at 0, capture `i_alu_res` into `o_rsp_data` and go to `RESP`.
- `RESP`:
  - `o_rsp_valid`=1; data and id are held stable until `i_rsp_ready`=1.
  - Then go to `IDLE`.
- Outside `ISSUE`/`WAIT`: `o_alu_sel_op`=`alu_nop` and operands = 0.
- `o_req_ready` is all-zero in every state other than `IDLE`. A new request is never accepted in the same cycle as the response handshake.
- Op codes pass through unchanged; no legality check.
- Reset mid-operation: the in-flight op is discarded with no response, and the arbitration pointer returns to 0.

## Timing
- Reset values: `o_req_ready`=0 while `i_rst_n`=0; `o_rsp_valid`=0; `o_rsp_id`=0; `o_rsp_data`=0; `o_alu_sel_op`=`alu_nop`; `o_alu_op_a`/`o_alu_op_b`=0; state `IDLE`.
- Request accepted at edge T:
  - ALU inputs are valid T+1 .. T+ALU_LAT.
  - `i_alu_res` is sampled at edge T+ALU_LAT+1.
  - `o_rsp_valid` rises after that edge.
- Minimum request-to-request spacing: ALU_LAT+3 cycles, assuming `i_rsp_ready` is held high.
- A requester must hold valid, op and operands stable until ready. Dropping valid before the grant is allowed, and that request is not served.

## Configuration
- `ALU_SCHED_RR_EN` defined:
  - Round-robin arbitration.
  - Pointer starts at 0.
  - After a grant to k, the pointer becomes (k+1) mod `N_REQ`.
  - Search starts at the pointer.
- `ALU_SCHED_RR_EN` undefined:
  - Fixed priority; lowest index wins.
  - No pointer register.

## Structure
- `pck_control` gains:
  - `sched_state_e`.
  - Localparam `ALU_OP_W`=5.
  - `sel_alu_op_e` (incl. `alu_nop`) is reused from the same package.
- One sub-module: `alu_sched_arbiter`.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; contains the `ALU_SCHED_RR_EN` selection.
- Pointer and FSM registers live in `alu_scheduler`.

## Test plan
- Reset, then idle:
  - Pulse `i_rst_n` low for 3 cycles.
  - All outputs stay at reset values; `o_alu_sel_op`=`alu_nop`.
- Single request:
  - Requester 2 sends op add, A=8'h12, B=8'h34; ALU model has ALU_LAT=2.
  - Expect `o_alu_*` visible T+1..T+2, and `o_rsp_valid` with id=2, data=8'h46 after edge T+3.
- Contention, all four requesting continuously:
  - `ALU_SCHED_RR_EN` defined: grant order 0,1,2,3,0.
  - Undefined: requester 0 is served every time.
- Backpressure:
  - Hold `i_rsp_ready`=0 for 5 cycles.
  - Response stays valid and stable; no `o_req_ready` asserted; release gives exactly one response.
- Reset mid-WAIT:
  - Assert `i_rst_n`=0 during `WAIT`.
  - No response is ever emitted; after release, the next request is served normally by requester 0 priority.
- Withdrawn request:
  - Requester 1 valid for 1 cycle while the scheduler is in `RESP`, then drops.
  - Requester 1 is never granted and produces no response.
